button_press_generator: RTL and testbench

//  Turns single-cycle request pulses into button-like level presses. Each accepted pulse becomes

---
 rtl/button_press_generator.sv | 150 +++++++++++++++
 tb/tb_button_press_generator.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_press_generator.sv
// ---------------------------------------------------------------------------
// button_press_generator
//
// Turns single-cycle request pulses into button-like level presses. Every
// accepted request becomes levelOut high for HOLD_CYCLES, followed by at
// least GAP_CYCLES low, so a downstream button shaper sees one clean press
// per request. Requests that arrive while a press is running are buffered
// in a saturating pending counter; a request that finds the counter full
// is dropped and latches the sticky overflow flag.
//
// Parameters
//   HOLD_CYCLES  cycles levelOut is held high per press (>=1)
//   GAP_CYCLES   minimum low cycles after each press (>=1)
//   PEND_W       width of the pending counter, max queued = 2**PEND_W-1
//
// Ports
//   Clk       in   system clock, all state updates on posedge
//   Rst       in   synchronous active-high reset
//   pulseIn   in   press request, each high cycle is one request
//   levelOut  out  generated button level (registered)
//   busy      out  high whenever a press or its gap is in progress (registered)
//   pending   out  presses accepted but not yet started
//   overflow  out  sticky, a request was dropped because pending was full
// ---------------------------------------------------------------------------
module button_press_generator #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              pulseIn,
  output logic              levelOut,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // The phase counter only ever reaches (longest phase - 1), so its width
  // just needs to cover the larger of the two phase lengths.
  localparam int PHASE_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

  localparam logic [PHASE_W-1:0] HOLD_LAST = PHASE_W'(HOLD_CYCLES - 1);
  localparam logic [PHASE_W-1:0] GAP_LAST  = PHASE_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0]  PEND_FULL = '1;

  state_t             state;
  state_t             state_next;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_next;
  logic [PEND_W-1:0]  pending_next;
  logic               overflow_next;
  logic               level_next;
  logic               busy_next;
  logic               enqueue;
  logic               dequeue;

  // Next-state logic. A request seen while idle starts a press directly and
  // never touches the pending counter. Requests during HOLD/GAP are queued.
  // At the last GAP cycle a new press starts if anything is queued, and a
  // request arriving on that very cycle counts as queued, so it is enqueued
  // and dequeued on the same edge and the counter is left untouched.
  always_comb begin
    state_next    = state;
    phase_next    = phase;
    pending_next  = pending;
    overflow_next = overflow;
    dequeue       = 1'b0;
    enqueue       = pulseIn && (state != IDLE);

    case (state)
      IDLE: begin
        if (pulseIn) begin
          state_next = HOLD;
          phase_next = '0;
        end
      end
      HOLD: begin
        if (phase == HOLD_LAST) begin
          state_next = GAP;
          phase_next = '0;
        end else begin
          phase_next = phase + PHASE_W'(1);
        end
      end
      GAP: begin
        if (phase == GAP_LAST) begin
          phase_next = '0;
          if ((pending != '0) || enqueue) begin
            state_next = HOLD;
            dequeue    = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          phase_next = phase + PHASE_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        phase_next = '0;
      end
    endcase

    // A simultaneous enqueue and dequeue cancel out, which is also what
    // lets a request be accepted on a full counter at a dequeue edge.
    if (enqueue && !dequeue) begin
      if (pending == PEND_FULL) begin
        overflow_next = 1'b1;
      end else begin
        pending_next = pending + PEND_W'(1);
      end
    end else if (dequeue && !enqueue) begin
      pending_next = pending - PEND_W'(1);
    end

    // Outputs are derived from the next state so they can be registered
    // and still line up with the state they describe.
    level_next = (state_next == HOLD);
    busy_next  = (state_next != IDLE);
  end

  // State and output registers. Reset aborts any press in progress and
  // discards the queue, including the sticky overflow flag.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      phase    <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      levelOut <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      phase    <= phase_next;
      pending  <= pending_next;
      overflow <= overflow_next;
      levelOut <= level_next;
      busy     <= busy_next;
    end
  end

endmodule

// File: tb/tb_button_press_generator.sv
// ---------------------------------------------------------------------------
// tb_button_press_generator
//
// Drives two instances of button_press_generator (default pending width and
// a 2-bit pending width for saturation) from the same stimulus and compares
// the selected one against a timeline scoreboard: every accepted request is
// queued with its request cycle and the cycle its press must start, and each
// cycle the expected level/busy/pending/overflow are derived from that queue.
// ---------------------------------------------------------------------------
module tb_button_press_generator;

  localparam int HOLD  = 4;
  localparam int GAP   = 2;
  localparam int PRESS = HOLD + GAP;

  logic       clock = 1'b0;
  logic       rst;
  logic       pulse;

  logic       big_level;
  logic       big_busy;
  logic [3:0] big_pending;
  logic       big_ovf;
  logic       small_level;
  logic       small_busy;
  logic [1:0] small_pending;
  logic       small_ovf;

  logic       obs_level;
  logic       obs_busy;
  logic [3:0] obs_pending;
  logic       obs_ovf;

  typedef struct {
    int req;
    int start;
  } press_t;

  press_t     sched[$];
  int         cyc        = 0;
  int         last_start = -100;
  int         model_max  = 15;
  bit         model_ovf  = 1'b0;
  bit         sel        = 1'b0;
  bit         check_on   = 1'b0;
  int         vectors    = 0;
  int         miscompares = 0;
  int         rise_count = 0;
  logic       prev_level = 1'b0;

  logic       mon_level;
  logic       mon_busy;
  int         mon_pend;
  logic [3:0] mon_pend4;

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  button_press_generator #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .PEND_W(4)) dut (
    .Clk      (clock),
    .Rst      (rst),
    .pulseIn  (pulse),
    .levelOut (big_level),
    .busy     (big_busy),
    .pending  (big_pending),
    .overflow (big_ovf)
  );

  button_press_generator #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .PEND_W(2)) dut_small (
    .Clk      (clock),
    .Rst      (rst),
    .pulseIn  (pulse),
    .levelOut (small_level),
    .busy     (small_busy),
    .pending  (small_pending),
    .overflow (small_ovf)
  );

  assign obs_level   = sel ? small_level : big_level;
  assign obs_busy    = sel ? small_busy  : big_busy;
  assign obs_pending = sel ? {2'b00, small_pending} : big_pending;
  assign obs_ovf     = sel ? small_ovf   : big_ovf;

  // Scoreboard monitor: one tick after each rising edge, retire presses that
  // have fully finished, rebuild the expected outputs for this cycle from the
  // queue of scheduled presses, and compare. Rising edges of the level are
  // counted here too, standing in for the downstream button shaper.
  always @(posedge clock) begin
    #1;
    cyc++;
    if (check_on) begin
      while (sched.size() > 0 && (sched[0].start + PRESS - 1) < cyc) begin
        void'(sched.pop_front());
      end
      mon_level = 1'b0;
      mon_busy  = 1'b0;
      mon_pend  = 0;
      foreach (sched[i]) begin
        if (cyc >= sched[i].start && cyc < sched[i].start + HOLD) mon_level = 1'b1;
        if (cyc >= sched[i].start && cyc < sched[i].start + PRESS) mon_busy = 1'b1;
        if (sched[i].req < cyc && sched[i].start > cyc) mon_pend++;
      end
      mon_pend4 = mon_pend[3:0];
      vectors++;
      if (obs_level !== mon_level) begin
        miscompares++;
        $display("[TB] FAIL sb_level cyc=%0d got=%b exp=%b", cyc, obs_level, mon_level);
      end
      vectors++;
      if (obs_busy !== mon_busy) begin
        miscompares++;
        $display("[TB] FAIL sb_busy cyc=%0d got=%b exp=%b", cyc, obs_busy, mon_busy);
      end
      vectors++;
      if (obs_pending !== mon_pend4) begin
        miscompares++;
        $display("[TB] FAIL sb_pending cyc=%0d got=%0d exp=%0d", cyc, obs_pending, mon_pend4);
      end
      vectors++;
      if (obs_ovf !== model_ovf) begin
        miscompares++;
        $display("[TB] FAIL sb_overflow cyc=%0d got=%b exp=%b", cyc, obs_ovf, model_ovf);
      end
      if (obs_level === 1'b1 && prev_level !== 1'b1) rise_count++;
    end
    prev_level = obs_level;
  end

  // Drive one cycle of stimulus and record what it should cause. A request
  // starts its press one cycle later if the generator is free, otherwise one
  // full press period after the last scheduled press. It is dropped only if
  // the queue is full and no queued press starts at the same edge.
  task automatic applyStimulus(input logic p, input logic r);
    int  pend;
    bit  deq;
    int  s;
    pulse = p;
    rst   = r;
    if (r) begin
      sched.delete();
      last_start = -100;
      model_ovf  = 1'b0;
    end else if (p) begin
      pend = 0;
      deq  = 1'b0;
      foreach (sched[i]) begin
        if (sched[i].start > cyc) pend++;
        if (sched[i].start == cyc + 1) deq = 1'b1;
      end
      if (pend < model_max || deq) begin
        s = (cyc + 1 > last_start + PRESS) ? cyc + 1 : last_start + PRESS;
        sched.push_back('{req: cyc, start: s});
        last_start = s;
      end else begin
        model_ovf = 1'b1;
      end
    end
    @(negedge clock);
  endtask

  // Idle the inputs until the selected instance goes quiet, with a bound.
  task automatic drain_idle(output bit timed_out);
    for (int i = 0; i < 200 && obs_busy !== 1'b0; i++) applyStimulus(1'b0, 1'b0);
    timed_out = (obs_busy !== 1'b0);
  endtask

  // Reset for two cycles and check every output is cleared.
  task automatic test_reset();
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    check_on = 1'b1;
    vectors++;
    if (obs_level !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_level got=%b exp=0", obs_level); end
    vectors++;
    if (obs_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got=%b exp=0", obs_busy); end
    vectors++;
    if (obs_pending !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_pending got=%0d exp=0", obs_pending); end
    vectors++;
    if (obs_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow got=%b exp=0", obs_ovf); end
  endtask

  // One request from idle: four cycles high, two low, then idle.
  task automatic test_single_press();
    logic exp_l;
    logic exp_b;
    applyStimulus(1'b1, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      exp_l = (k <= HOLD);
      exp_b = (k <= PRESS);
      vectors++;
      if (obs_level !== exp_l) begin miscompares++; $display("[TB] FAIL single_level k=%0d got=%b exp=%b", k, obs_level, exp_l); end
      vectors++;
      if (obs_busy !== exp_b) begin miscompares++; $display("[TB] FAIL single_busy k=%0d got=%b exp=%b", k, obs_busy, exp_b); end
      vectors++;
      if (obs_pending !== 4'd0) begin miscompares++; $display("[TB] FAIL single_pending k=%0d got=%0d exp=0", k, obs_pending); end
      applyStimulus(1'b0, 1'b0);
    end
    vectors++;
    if (obs_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL single_overflow got=%b exp=0", obs_ovf); end
  endtask

  // Three requests on consecutive cycles from idle: queue builds to 2 and
  // three presses run back to back for 18 busy cycles.
  task automatic test_back_to_back();
    int r0;
    int busy_cycles;
    bit to;
    r0 = rise_count;
    busy_cycles = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0);
      if (obs_busy === 1'b1) busy_cycles++;
      vectors++;
      if (obs_pending !== 4'(k)) begin miscompares++; $display("[TB] FAIL b2b_pending k=%0d got=%0d exp=%0d", k, obs_pending, k); end
    end
    for (int i = 0; i < 40 && obs_busy === 1'b1; i++) begin
      applyStimulus(1'b0, 1'b0);
      if (obs_busy === 1'b1) busy_cycles++;
    end
    drain_idle(to);
    vectors++;
    if (to) begin miscompares++; $display("[TB] FAIL b2b_timeout got=busy exp=idle"); end
    vectors++;
    if (busy_cycles != 3 * PRESS) begin miscompares++; $display("[TB] FAIL b2b_busy_cycles got=%0d exp=%0d", busy_cycles, 3 * PRESS); end
    vectors++;
    if (rise_count - r0 != 3) begin miscompares++; $display("[TB] FAIL b2b_presses got=%0d exp=3", rise_count - r0); end
  endtask

  // A request on the final gap cycle with nothing queued goes straight into
  // the next press without touching pending.
  task automatic test_final_gap();
    int r0;
    bit to;
    r0 = rise_count;
    applyStimulus(1'b1, 1'b0);
    repeat (HOLD + GAP - 1) applyStimulus(1'b0, 1'b0);
    vectors++;
    if (obs_level !== 1'b0 || obs_busy !== 1'b1) begin
      miscompares++; $display("[TB] FAIL lastgap_state got=%b%b exp=01", obs_level, obs_busy);
    end
    applyStimulus(1'b1, 1'b0);
    vectors++;
    if (obs_level !== 1'b1) begin miscompares++; $display("[TB] FAIL lastgap_restart got=%b exp=1", obs_level); end
    vectors++;
    if (obs_pending !== 4'd0) begin miscompares++; $display("[TB] FAIL lastgap_pending got=%0d exp=0", obs_pending); end
    drain_idle(to);
    vectors++;
    if (to) begin miscompares++; $display("[TB] FAIL lastgap_timeout got=busy exp=idle"); end
    vectors++;
    if (rise_count - r0 != 2) begin miscompares++; $display("[TB] FAIL lastgap_presses got=%0d exp=2", rise_count - r0); end
  endtask

  // With a 2-bit queue, keep requesting during a press: the queue stops at 3,
  // further requests are dropped, and overflow latches.
  task automatic test_saturation();
    int r0;
    bit to;
    int exp_p;
    applyStimulus(1'b0, 1'b1);
    sel = 1'b1;
    model_max = 3;
    r0 = rise_count;
    applyStimulus(1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 1'b0);
      exp_p = (k < 3) ? k : 3;
      vectors++;
      if (obs_pending !== 4'(exp_p)) begin miscompares++; $display("[TB] FAIL sat_pending k=%0d got=%0d exp=%0d", k, obs_pending, exp_p); end
      vectors++;
      if (obs_ovf !== logic'(k >= 4)) begin miscompares++; $display("[TB] FAIL sat_overflow k=%0d got=%b exp=%b", k, obs_ovf, k >= 4); end
    end
    drain_idle(to);
    vectors++;
    if (to) begin miscompares++; $display("[TB] FAIL sat_timeout got=busy exp=idle"); end
    vectors++;
    if (rise_count - r0 != 4) begin miscompares++; $display("[TB] FAIL sat_presses got=%0d exp=4", rise_count - r0); end
    vectors++;
    if (obs_ovf !== 1'b1) begin miscompares++; $display("[TB] FAIL sat_sticky got=%b exp=1", obs_ovf); end
  endtask

  // Reset in the middle of a press with two requests queued.
  task automatic test_reset_mid();
    int r0;
    applyStimulus(1'b0, 1'b1);
    sel = 1'b0;
    model_max = 15;
    r0 = rise_count;
    repeat (3) applyStimulus(1'b1, 1'b0);
    vectors++;
    if (obs_pending !== 4'd2) begin miscompares++; $display("[TB] FAIL rstmid_pre_pending got=%0d exp=2", obs_pending); end
    applyStimulus(1'b0, 1'b1);
    vectors++;
    if (obs_level !== 1'b0 || obs_busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rstmid_abort got=%b%b exp=00", obs_level, obs_busy);
    end
    vectors++;
    if (obs_pending !== 4'd0 || obs_ovf !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rstmid_clear got=%0d/%b exp=0/0", obs_pending, obs_ovf);
    end
    repeat (12) applyStimulus(1'b0, 1'b0);
    vectors++;
    if (rise_count - r0 != 1) begin miscompares++; $display("[TB] FAIL rstmid_presses got=%0d exp=1", rise_count - r0); end
  endtask

  // Fifty requests with random spacing no tighter than one press period,
  // counted as shaper pulses on the level output.
  task automatic test_shaper_chain();
    int r0;
    int gap;
    bit to;
    r0 = rise_count;
    for (int n = 0; n < 50; n++) begin
      applyStimulus(1'b1, 1'b0);
      gap = $urandom_range(PRESS - 1, 12);
      repeat (gap) applyStimulus(1'b0, 1'b0);
    end
    drain_idle(to);
    vectors++;
    if (to) begin miscompares++; $display("[TB] FAIL chain_timeout got=busy exp=idle"); end
    vectors++;
    if (rise_count - r0 != 50) begin miscompares++; $display("[TB] FAIL chain_presses got=%0d exp=50", rise_count - r0); end
    vectors++;
    if (obs_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL chain_overflow got=%b exp=0", obs_ovf); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    rst   = 1'b1;
    pulse = 1'b0;
    @(negedge clock);
    test_reset();
    test_single_press();
    test_back_to_back();
    test_final_gap();
    test_saturation();
    test_reset_mid();
    test_shaper_chain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
